// File: rtl/mealy_machine_001_pkg.sv
// Shared state encoding for the "001" serial pattern detector.
// Build option MEALY_001_CNT_EN (in the top) adds a saturating match counter.
package mealy_machine_001_pkg;

   localparam int STATE_W = 2;

   // 2'b11 is never entered by legal operation; it only exists so the FSM can recover from it.
   typedef enum logic [STATE_W-1:0] {
      S0    = 2'b00,
      S1    = 2'b01,
      S2    = 2'b10,
      S_ILL = 2'b11
   } state_t;

endpackage

// File: rtl/mealy_machine_001.sv
// Mealy detector for the serial pattern 0,0,1; det is combinational from pr_state and inp.
// Define MEALY_001_CNT_EN to add match_cnt, a saturating count of detections.
module mealy_machine_001
   import mealy_machine_001_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inp,
   output logic               det,
   output logic [STATE_W-1:0] dbg_state
`ifdef MEALY_001_CNT_EN
   ,
   output logic [CNT_W-1:0]   match_cnt
`endif
);

   // Interface: no handshake; one input bit is consumed on every rising clk edge.

   state_t pr_state;
   state_t nx_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         pr_state <= S0;
      end else begin
         pr_state <= nx_state;
      end
   end

   always_comb begin
      nx_state = S0;
      det      = 1'b0;
      case (pr_state)
         S0: nx_state = inp ? S0 : S1;
         S1: nx_state = inp ? S0 : S2;
         S2: begin
            nx_state = inp ? S0 : S2;
            det      = inp & ~reset;
         end
         default: nx_state = S0;
      endcase
   end

   assign dbg_state = pr_state;

`ifdef MEALY_001_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         match_cnt <= '0;
      end else if (det && (match_cnt != {CNT_W{1'b1}})) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mealy_machine_001.sv
// Self-checking bench for mealy_machine_001: vector table, random stream and counter saturation.
// Honours MEALY_001_CNT_EN to also check match_cnt.
module tb_mealy_machine_001;

   logic       clk;
   logic       reset;
   logic       inp;
   logic       det;
   logic [1:0] dbg_state;
`ifdef MEALY_001_CNT_EN
   logic [7:0] match_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard entries are {state, det} expected for the cycle being driven.
   logic [2:0] exp_q[$];

   typedef struct packed {
      logic       rst;
      logic       in_bit;
      logic [1:0] st;
      logic       det;
      logic [7:0] cnt;
   } vec_t;

   vec_t vq[$];

   mealy_machine_001 #(.CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .inp       (inp),
      .det       (det),
      .dbg_state (dbg_state)
`ifdef MEALY_001_CNT_EN
      ,
      .match_cnt (match_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic i);
      @(negedge clk);
      reset = r;
      inp   = i;
   endtask

   task automatic compare_front(input string name);
      logic [2:0] e;
      #1;
      if (exp_q.size() == 0) begin
         check({name, "_queue_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check({name, "_state"}, int'(dbg_state), int'(e[2:1]));
         check({name, "_det"}, int'(det), int'(e[0]));
      end
   endtask

   task automatic add(input logic r, input logic i, input logic [1:0] s,
                      input logic d, input logic [7:0] c);
      vec_t v;
      v.rst = r; v.in_bit = i; v.st = s; v.det = d; v.cnt = c;
      vq.push_back(v);
   endtask

   int         zr;
   logic       rb;
   logic [1:0] es;
   int         exp_cnt;

   initial begin
      reset = 1'b1;
      inp   = 1'b0;
      // Bring state out of X before the table begins.
      @(negedge clk);
      @(negedge clk);

      // reset, then 0,0,1
      add(1, 0, 2'b00, 0, 0);
      add(0, 0, 2'b00, 0, 0);
      add(0, 0, 2'b01, 0, 0);
      add(0, 1, 2'b10, 1, 0);
      // reset, then 0,0,1,0,0,1,1
      add(1, 0, 2'b00, 0, 1);
      add(0, 0, 2'b00, 0, 0);
      add(0, 0, 2'b01, 0, 0);
      add(0, 1, 2'b10, 1, 0);
      add(0, 0, 2'b00, 0, 1);
      add(0, 0, 2'b01, 0, 1);
      add(0, 1, 2'b10, 1, 1);
      add(0, 1, 2'b00, 0, 2);
      // 0,0,0,0,1
      add(0, 0, 2'b00, 0, 2);
      add(0, 0, 2'b01, 0, 2);
      add(0, 0, 2'b10, 0, 2);
      add(0, 0, 2'b10, 0, 2);
      add(0, 1, 2'b10, 1, 2);
      // 0,1,0,1,1
      add(0, 0, 2'b00, 0, 3);
      add(0, 1, 2'b01, 0, 3);
      add(0, 0, 2'b00, 0, 3);
      add(0, 1, 2'b01, 0, 3);
      add(0, 1, 2'b00, 0, 3);
      // reset while in S2 with inp=1
      add(0, 0, 2'b00, 0, 3);
      add(0, 0, 2'b01, 0, 3);
      add(1, 1, 2'b10, 0, 3);
      add(0, 1, 2'b00, 0, 0);

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].rst, vq[k].in_bit);
         exp_q.push_back({vq[k].st, vq[k].det});
         compare_front($sformatf("vec%0d", k));
`ifdef MEALY_001_CNT_EN
         check($sformatf("vec%0d_cnt", k), int'(match_cnt), int'(vq[k].cnt));
`endif
      end

      // Random stream against a zero-run model: det needs >=2 zeros since the last 1 or reset.
      drive(1, 0);
      zr      = 0;
      exp_cnt = 0;
      for (int k = 0; k < 200; k++) begin
         rb = 1'($urandom_range(0, 1));
         drive(0, rb);
         es = (zr == 0) ? 2'b00 : (zr == 1) ? 2'b01 : 2'b10;
         exp_q.push_back({es, rb & (zr >= 2)});
         compare_front($sformatf("rnd%0d", k));
         if (rb && zr >= 2) exp_cnt++;
         zr = rb ? 0 : zr + 1;
      end
`ifdef MEALY_001_CNT_EN
      @(negedge clk);
      check("rnd_cnt", int'(match_cnt), exp_cnt);

      // Saturation: 260 detections must stop at 255.
      drive(1, 0);
      for (int k = 0; k < 260; k++) begin
         drive(0, 0);
         drive(0, 0);
         drive(0, 1);
      end
      drive(0, 1);
      #1;
      check("cnt_saturate", int'(match_cnt), 255);
      drive(1, 0);
      @(negedge clk);
      check("cnt_reset_clear", int'(match_cnt), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
